neuron_update: RTL and testbench

NEURON_UPDATE -- requirements
Module: neuron_update

---
 rtl/neuron_update.sv | 158 +++++++++++++++
 tb/tb_neuron_update.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/neuron_update.sv
// neuron_update: leaky integrate-and-fire potential update with sweep leak/fire, external injection and spike FIFO.
// Optional macro SPIKE_DROP_CNT_EN adds an 8-bit saturating drop_cnt output.
module neuron_update #(
    parameter int NEURON_NO  = 2**8,
    parameter int POT_W      = 16,
    parameter int THRESHOLD  = 1000,
    parameter int LEAK       = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         testing_en,
    input  logic [$clog2(NEURON_NO)-1:0] testing_addr,
    input  logic                         sel,
    input  logic [1:0]                   ext_req,
    input  logic [$clog2(NEURON_NO)-1:0] ext_addr,
    input  logic [POT_W-1:0]             ext_weight,
    output logic                         ext_ack,
    output logic                         spike_valid,
    output logic [$clog2(NEURON_NO)-1:0] spike_addr,
    input  logic                         spike_ready,
    output logic                         spike_drop
`ifdef SPIKE_DROP_CNT_EN
    ,
    output logic [7:0]                   drop_cnt
`endif
);
    localparam int AW = $clog2(NEURON_NO);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [POT_W-1:0] LEAK_V = POT_W'(LEAK);
    localparam logic [POT_W-1:0] THR_V  = POT_W'(THRESHOLD);
    localparam logic [1:0] IDLE = 2'd0, SW_WR = 2'd1, EXT_RD = 2'd2, EXT_WR = 2'd3;

    logic [POT_W-1:0] pot_mem [NEURON_NO] = '{default: '0};
    logic [AW-1:0]    fifo_mem [FIFO_DEPTH];

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [POT_W-1:0] pot_q, pot_d;
    logic             ack_q, ack_d;
    logic [POT_W-1:0] rd_q;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [POT_W-1:0] mem_wdata;
    logic             push;
    logic [POT_W-1:0] lk, ext_res;
    logic [POT_W:0]   sum;
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             pop, full, wr, drop_ev;

    assign lk      = rd_q > LEAK_V ? rd_q - LEAK_V : '0;
    assign sum     = {1'b0, pot_q} + {1'b0, ext_weight};
    assign ext_res = ext_req == 2'b01 ? (sum[POT_W] ? '1 : sum[POT_W-1:0]) :
                     ext_req == 2'b10 ? (pot_q > ext_weight ? pot_q - ext_weight : '0) : pot_q;

    // Requests seen during the ack cycle belong to the injection just completed.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pot_d     = pot_q;
        ack_d     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = '0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ext_req != 2'b00 && !ack_q) begin
                    mem_addr = ext_addr;
                    addr_d   = ext_addr;
                    state_d  = EXT_RD;
                end else if (testing_en && sel) begin
                    mem_addr = testing_addr;
                    addr_d   = testing_addr;
                    state_d  = SW_WR;
                end
            end
            SW_WR: begin
                push      = lk >= THR_V;
                mem_we    = 1'b1;
                mem_wdata = push ? '0 : lk;
                state_d   = IDLE;
            end
            EXT_RD: begin
                pot_d   = rd_q;
                state_d = EXT_WR;
            end
            default: begin
                mem_we    = 1'b1;
                mem_wdata = ext_res;
                ack_d     = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) pot_mem[mem_addr] <= mem_wdata;
        rd_q <= pot_mem[mem_addr];
    end

    always_comb begin
        pop     = spike_ready && cnt_q != '0;
        full    = cnt_q == (PW+1)'(FIFO_DEPTH);
        wr      = push && (!full || pop);
        drop_ev = push && full && !pop;
        wp_d    = wp_q + PW'(wr);
        rp_d    = rp_q + PW'(pop);
        cnt_d   = cnt_q + (PW+1)'(wr) - (PW+1)'(pop);
        drop_d  = drop_q || drop_ev;
    end

    always_ff @(posedge clk) begin
        if (wr) fifo_mem[wp_q] <= addr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pot_q   <= '0;
            ack_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pot_q   <= pot_d;
            ack_q   <= ack_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    assign ext_ack     = ack_q;
    assign spike_valid = cnt_q != '0;
    assign spike_addr  = spike_valid ? fifo_mem[rp_q] : '0;
    assign spike_drop  = drop_q;

`ifdef SPIKE_DROP_CNT_EN
    logic [7:0] dcnt_q, dcnt_d;

    always_comb dcnt_d = drop_ev && dcnt_q != 8'hFF ? dcnt_q + 8'd1 : dcnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) dcnt_q <= '0;
        else        dcnt_q <= dcnt_d;
    end

    assign drop_cnt = dcnt_q;
`endif
endmodule

// File: tb/tb_neuron_update.sv
// tb_neuron_update: scoreboard bench for neuron_update; expected acks and spikes are queued by stimulus and checked by monitors.
module tb_neuron_update;
    logic       clk = 0, reset = 0, testing_en = 0, sel = 0, spike_ready = 0;
    logic [1:0] ext_req = 0;
    logic [7:0] testing_addr = 0, ext_addr = 0;
    logic [15:0] ext_weight = 0;
    logic       ext_ack, spike_valid, spike_drop;
    logic [7:0] spike_addr;
`ifdef SPIKE_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    typedef struct {int a; int v;} ack_t;
    ack_t ack_q[$];
    ack_t ack_e;
    int   spk_q[$];
    int   n_chk = 0, n_fail = 0, cyc = 0;
    logic pv = 0, pr = 0;
    logic [7:0] pa = 0;

    neuron_update dut (
        .clk(clk), .reset(reset), .testing_en(testing_en), .testing_addr(testing_addr),
        .sel(sel), .ext_req(ext_req), .ext_addr(ext_addr), .ext_weight(ext_weight),
        .ext_ack(ext_ack), .spike_valid(spike_valid), .spike_addr(spike_addr),
        .spike_ready(spike_ready), .spike_drop(spike_drop)
`ifdef SPIKE_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Ack monitor: each ack must match a queued injection and its written potential.
    always @(negedge clk) begin
        if (reset && ext_ack) begin
            if (ack_q.size() == 0) chk("unexpected_ack", 1, 0);
            else begin
                ack_e = ack_q.pop_front();
                chk("ack_pot", int'(dut.pot_mem[ack_e.a]), ack_e.v);
            end
        end
    end

    // Spike monitor: pops compared in order; head must hold while stalled.
    always @(negedge clk) begin
        if (reset && spike_valid && spike_ready) begin
            if (spk_q.size() == 0) chk("unexpected_spike", 1, 0);
            else chk("spike_addr", int'(spike_addr), spk_q.pop_front());
        end
        if (reset && pv && !pr && spike_valid) chk("spike_hold", int'(spike_addr), int'(pa));
        pv = reset && spike_valid;
        pr = spike_ready;
        pa = spike_addr;
    end

    task automatic wait_ack(input int lat, input int t0);
        int n = 0;
        while (!ext_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ext_ack) chk("ack_timeout", 0, 1);
        else chk("ack_latency", cyc - t0, lat);
        ext_req = 0;
    endtask

    task automatic inject(input logic [1:0] r, input int a, input int w, input int v);
        ack_t e;
        e.a = a;
        e.v = v;
        ack_q.push_back(e);
        @(posedge clk); #1;
        ext_req = r; ext_addr = 8'(a); ext_weight = 16'(w);
        wait_ack(3, cyc);
    endtask

    task automatic sweep(input int a);
        @(posedge clk); #1;
        testing_en = 1; sel = 1; testing_addr = 8'(a);
        @(posedge clk); #1;
        sel = 0;
        @(posedge clk); #1;
        testing_en = 0;
    endtask

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", int'(ext_ack), 0);
        chk("rst_valid", int'(spike_valid), 0);
        chk("rst_addr", int'(spike_addr), 0);
        chk("rst_drop", int'(spike_drop), 0);
        @(posedge clk); #1 reset = 1;

        inject(2'b01, 5, 10, 10);
        inject(2'b01, 7, 1001, 1001);
        inject(2'b01, 20, 50, 50);
        for (int a = 10; a <= 15; a++) inject(2'b01, a, 1001, 1001);

        sweep(5);
        @(negedge clk);
        chk("leak_pot5", int'(dut.pot_mem[5]), 9);
        chk("leak_no_spike", int'(spike_valid), 0);

        spk_q.push_back(7);
        @(posedge clk); #1 testing_en = 1; sel = 1; testing_addr = 7;
        @(posedge clk); #1 sel = 0;
        @(negedge clk) chk("fire_valid_pre", int'(spike_valid), 0);
        @(posedge clk); #1 testing_en = 0;
        @(negedge clk);
        chk("fire_pot7", int'(dut.pot_mem[7]), 0);
        chk("fire_valid", int'(spike_valid), 1);
        chk("fire_addr", int'(spike_addr), 7);
        @(posedge clk); #1 spike_ready = 1;
        @(posedge clk); #1 spike_ready = 0;
        @(negedge clk) chk("fire_popped", int'(spike_valid), 0);

        inject(2'b01, 3, 65000, 65000);
        inject(2'b01, 3, 65000, 65535);
        inject(2'b10, 3, 70000, 61071);
        inject(2'b10, 3, 65000, 0);
        inject(2'b11, 3, 123, 0);

        for (int a = 10; a <= 14; a++) begin
            if (a < 14) spk_q.push_back(a);
            sweep(a);
        end
        @(negedge clk);
        chk("ovf_drop", int'(spike_drop), 1);
        chk("ovf_valid", int'(spike_valid), 1);
        chk("ovf_head", int'(spike_addr), 10);
        chk("ovf_pot14", int'(dut.pot_mem[14]), 0);
`ifdef SPIKE_DROP_CNT_EN
        chk("ovf_drop_cnt", int'(drop_cnt), 1);
`endif
        spk_q.push_back(15);
        @(posedge clk); #1 testing_en = 1; sel = 1; testing_addr = 15;
        @(posedge clk); #1 sel = 0; spike_ready = 1;
        @(posedge clk); #1 testing_en = 0; spike_ready = 0;
        @(negedge clk);
        chk("full_pushpop_head", int'(spike_addr), 11);
        chk("full_pot15", int'(dut.pot_mem[15]), 0);
`ifdef SPIKE_DROP_CNT_EN
        chk("full_drop_cnt", int'(drop_cnt), 1);
`endif
        @(posedge clk); #1 spike_ready = 1;
        repeat (6) @(posedge clk);
        #1 spike_ready = 0;
        @(negedge clk);
        chk("drain_valid", int'(spike_valid), 0);
        chk("drain_queue", spk_q.size(), 0);

        ack_e.a = 21; ack_e.v = 5;
        ack_q.push_back(ack_e);
        @(posedge clk); #1 testing_en = 1; sel = 1; testing_addr = 20;
        @(posedge clk); #1 sel = 0; ext_req = 2'b01; ext_addr = 21; ext_weight = 5; t0 = cyc;
        @(posedge clk); #1 testing_en = 0;
        wait_ack(4, t0);
        chk("coll_sweep_pot20", int'(dut.pot_mem[20]), 49);

        @(posedge clk); #1 ext_req = 2'b01; ext_addr = 22; ext_weight = 9;
        @(posedge clk); #1;
        chk("rst_mid_state", int'(dut.state_q), 2);
        reset = 0;
        #1;
        chk("rst_mid_ack", int'(ext_ack), 0);
        chk("rst_mid_valid", int'(spike_valid), 0);
        chk("rst_mid_addr", int'(spike_addr), 0);
        chk("rst_mid_drop", int'(spike_drop), 0);
        ext_req = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) chk("rst_mid_pot22", int'(dut.pot_mem[22]), 0);
        @(posedge clk); #1 reset = 1;
        repeat (4) @(negedge clk);
        chk("rst_rel_state", int'(dut.state_q), 0);
        chk("rst_rel_ack", int'(ext_ack), 0);
        chk("rst_rel_drop", int'(spike_drop), 0);
        chk("ack_queue", ack_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
